// File: rtl/mult8x8_err_pkg.sv
// Shared types and constants for the 8x8 multiplier error-characterisation stage.
package mult8x8_err_pkg;

    // Operand width of the multiplier under test and width of its product / error distance.
    localparam int OP_W = 8;
    localparam int ED_W = 16;

    // Default accumulator and counter widths; 17-bit counters hold a full 65536-pair sweep.
    localparam int ACC_W_DEF = 32;
    localparam int CNT_W_DEF = 17;

    // Run controller states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/abs_diff16.sv
// Unsigned absolute difference |x - y| of two 16-bit values (combinational).
module abs_diff16
    import mult8x8_err_pkg::*;
(
    input  logic [ED_W-1:0] x_i,
    input  logic [ED_W-1:0] y_i,
    output logic [ED_W-1:0] d_o
);

    // Subtract the smaller from the larger so the result never wraps.
    assign d_o = (x_i >= y_i) ? (x_i - y_i) : (y_i - x_i);

endmodule

// File: rtl/mult8x8_err_accum.sv
// Error accumulator for approximate 8x8 multipliers: computes ED = |A*B - R| per sample
// and gathers sum/max of ED, error count and sample count over a programmed run.
// Pipeline: accept -> S1 (operands) -> S2 (ED) -> accumulate.
module mult8x8_err_accum
    import mult8x8_err_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_a,
    input  logic [OP_W-1:0]  in_b,
    input  logic [ED_W-1:0]  in_r,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] sum_ed,
    output logic [ED_W-1:0]  max_ed,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] smp_cnt,
    output logic             overflow
);

    // ---------------------------------------------------------------
    // Run control
    // ---------------------------------------------------------------
    state_t           state_q, state_d;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] acc_cnt_q;

    logic start_ok;
    logic accept;
    logic last_accept;

    // Pipeline stage registers
    logic             s1_valid_q;
    logic [OP_W-1:0]  s1_a_q;
    logic [OP_W-1:0]  s1_b_q;
    logic [ED_W-1:0]  s1_r_q;
    logic             s2_valid_q;
    logic [ED_W-1:0]  s2_ed_q;

    // Result registers
    logic [ACC_W-1:0] sum_q;
    logic [ED_W-1:0]  max_q;
    logic [CNT_W-1:0] err_q;
    logic [CNT_W-1:0] smp_q;
    logic             ovf_q;

    // start is only honoured while idle; anywhere else it is ignored.
    assign start_ok    = (state_q == IDLE) && start;
    assign in_ready    = (state_q == RUN) && (acc_cnt_q < target_q);
    assign accept      = in_valid && in_ready;
    assign last_accept = accept && (acc_cnt_q == (target_q - CNT_W'(1)));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero-length runs skip RUN and go straight to DRAIN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = (num_samples != '0) ? RUN : DRAIN;
                end
            end
            RUN: begin
                if (last_accept) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                // Both stages empty means the last sample has been accumulated.
                if (!s1_valid_q && !s2_valid_q) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy = (state_q == RUN) || (state_q == DRAIN);
    assign done = (state_q == DONE);

    // Run target capture and accepted-sample counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target_q  <= '0;
            acc_cnt_q <= '0;
        end else if (start_ok) begin
            target_q  <= num_samples;
            acc_cnt_q <= '0;
        end else if (accept) begin
            acc_cnt_q <= acc_cnt_q + CNT_W'(1);
        end
    end

    // ---------------------------------------------------------------
    // S1: register the accepted tuple
    // ---------------------------------------------------------------
    // Operands are only captured on accept so idle bus activity is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_a_q     <= '0;
            s1_b_q     <= '0;
            s1_r_q     <= '0;
        end else begin
            s1_valid_q <= accept;
            if (accept) begin
                s1_a_q <= in_a;
                s1_b_q <= in_b;
                s1_r_q <= in_r;
            end
        end
    end

    // ---------------------------------------------------------------
    // S2: exact product and error distance
    // ---------------------------------------------------------------
    logic [ED_W-1:0] exact_prod;
    logic [ED_W-1:0] ed_comb;

    // An 8x8 unsigned product always fits in 16 bits.
    assign exact_prod = ED_W'(s1_a_q) * ED_W'(s1_b_q);

    abs_diff16 u_abs_diff (
        .x_i (exact_prod),
        .y_i (s1_r_q),
        .d_o (ed_comb)
    );

    // Register the error distance of the sample in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_ed_q    <= '0;
        end else begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_ed_q <= ed_comb;
            end
        end
    end

    // ---------------------------------------------------------------
    // Accumulate
    // ---------------------------------------------------------------
    logic [ACC_W:0] sum_ext;
    logic           sum_sat;

    // One extra bit catches the carry out that signals saturation.
    assign sum_ext = {1'b0, sum_q} + (ACC_W + 1)'(s2_ed_q);
    assign sum_sat = sum_ext[ACC_W];

    // Results clear on an accepted start and update once per sample leaving S2.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum_q <= '0;
            max_q <= '0;
            err_q <= '0;
            smp_q <= '0;
            ovf_q <= 1'b0;
        end else if (start_ok) begin
            sum_q <= '0;
            max_q <= '0;
            err_q <= '0;
            smp_q <= '0;
            ovf_q <= 1'b0;
        end else if (s2_valid_q) begin
            smp_q <= smp_q + CNT_W'(1);
            if (s2_ed_q != '0) begin
                err_q <= err_q + CNT_W'(1);
            end
            if (s2_ed_q > max_q) begin
                max_q <= s2_ed_q;
            end
            if (sum_sat) begin
                sum_q <= '1;
                ovf_q <= 1'b1;
            end else begin
                sum_q <= sum_ext[ACC_W-1:0];
            end
        end
    end

    assign sum_ed   = sum_q;
    assign max_ed   = max_q;
    assign err_cnt  = err_q;
    assign smp_cnt  = smp_q;
    assign overflow = ovf_q;

endmodule

// File: tb/tb_mult8x8_err_accum.sv
// Randomised + directed bench for mult8x8_err_accum with a timeline-based reference model.
module tb_mult8x8_err_accum;

    localparam int ACC_W = 17;
    localparam int CNT_W = 17;
    localparam longint MAXS = (64'd1 << ACC_W) - 1;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_samples;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_a;
    logic [7:0]       in_b;
    logic [15:0]      in_r;
    logic             busy;
    logic             done;
    logic [ACC_W-1:0] sum_ed;
    logic [15:0]      max_ed;
    logic [CNT_W-1:0] err_cnt;
    logic [CNT_W-1:0] smp_cnt;
    logic             overflow;

    mult8x8_err_accum #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_samples (num_samples),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_r        (in_r),
        .busy        (busy),
        .done        (done),
        .sum_ed      (sum_ed),
        .max_ed      (max_ed),
        .err_cnt     (err_cnt),
        .smp_cnt     (smp_cnt),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit cmp_en = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Results of a sample accepted at edge t become visible after edge t+2;
    // done is high for the cycle after edge t+3 (or start edge + 1 for an empty run).
    typedef struct { int due; int ed; } pend_t;
    pend_t  pq[$];
    int     n_edge;
    int     done_edge;
    int     m_acc;
    int     m_target;
    bit     m_busy, m_done, m_ready, m_ovf;
    longint m_sum;
    int     m_max, m_err, m_smp;

    task automatic model_clear();
        pq.delete();
        done_edge = -1;
        m_acc = 0; m_target = 0;
        m_busy = 0; m_done = 0; m_ready = 0; m_ovf = 0;
        m_sum = 0; m_max = 0; m_err = 0; m_smp = 0;
    endtask

    task automatic model_step();
        bit pb, pd, pr;
        int p, ed;
        pend_t e;
        n_edge++;
        pb = m_busy; pd = m_done; pr = m_ready;
        while (pq.size() > 0 && pq[0].due == n_edge) begin
            e = pq.pop_front();
            m_smp++;
            if (e.ed != 0) m_err++;
            if (e.ed > m_max) m_max = e.ed;
            if (m_sum + e.ed > MAXS) begin
                m_sum = MAXS;
                m_ovf = 1;
            end else begin
                m_sum = m_sum + e.ed;
            end
        end
        m_done = (n_edge == done_edge);
        if (m_done) m_busy = 0;
        if (pr && in_valid) begin
            p  = int'(in_a) * int'(in_b);
            ed = (p > int'(in_r)) ? p - int'(in_r) : int'(in_r) - p;
            pq.push_back('{n_edge + 2, ed});
            m_acc++;
            if (m_acc == m_target) begin
                m_ready = 0;
                done_edge = n_edge + 3;
            end
        end
        if (!pb && !pd && start) begin
            m_sum = 0; m_max = 0; m_err = 0; m_smp = 0; m_ovf = 0;
            m_target = int'(num_samples);
            m_acc = 0;
            m_busy = 1;
            if (num_samples != 0) m_ready = 1;
            else done_edge = n_edge + 1;
        end
    endtask

    initial begin
        n_edge = 0;
        model_clear();
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_clear();
            else model_step();
        end
    end

    // ---------------- cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (cmp_en) begin
                chk("in_ready", in_ready, m_ready);
                chk("busy",     busy,     m_busy);
                chk("done",     done,     m_done);
                chk("sum_ed",   sum_ed,   m_sum);
                chk("max_ed",   max_ed,   m_max);
                chk("err_cnt",  err_cnt,  m_err);
                chk("smp_cnt",  smp_cnt,  m_smp);
                chk("overflow", overflow, m_ovf);
            end
        end
    end

    // ---------------- stimulus ----------------
    int op_a [64];
    int op_b [64];
    int op_r [64];

    task automatic set_tuple(input int i, input int a, input int b, input int r);
        op_a[i] = a; op_b[i] = b; op_r[i] = r;
    endtask

    task automatic gen_random(input int n);
        int p, r;
        for (int i = 0; i < n; i++) begin
            op_a[i] = $urandom_range(255);
            op_b[i] = $urandom_range(255);
            p = op_a[i] * op_b[i];
            case ($urandom_range(3))
                0, 1: r = p;
                2: begin
                    r = p + $urandom_range(600) - 300;
                    if (r < 0) r = 0;
                    if (r > 65535) r = 65535;
                end
                default: r = $urandom_range(65535);
            endcase
            op_r[i] = r;
        end
    endtask

    // Runs one start..done sequence; leaves the bench at the negedge where done is high.
    task automatic do_run(input int n, input int vpct, input bit pulse_start);
        int budget;
        int idx;
        @(negedge clk);
        start = 1; num_samples = CNT_W'(n);
        @(negedge clk);
        start = 0; num_samples = CNT_W'($urandom);
        budget = 0;
        while (!done && budget < 500) begin
            in_valid = ($urandom_range(99) < vpct);
            idx = (m_acc < 64) ? m_acc : 63;
            if (in_valid) begin
                in_a = 8'(op_a[idx]); in_b = 8'(op_b[idx]); in_r = 16'(op_r[idx]);
            end else begin
                in_a = 8'($urandom); in_b = 8'($urandom); in_r = 16'($urandom);
            end
            if (pulse_start && budget == 1) begin
                start = 1; num_samples = CNT_W'(7);
            end else begin
                start = 0;
            end
            @(negedge clk);
            budget++;
        end
        start = 0;
        in_valid = 0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL done_timeout: got done=%0d expected 1 within 500 cycles", done);
        end
    endtask

    task automatic chk_results(input string tag, input longint s, input longint mx,
                               input longint ec, input longint sc, input longint ov);
        chk({tag, "_sum"}, sum_ed,   s);
        chk({tag, "_max"}, max_ed,   mx);
        chk({tag, "_err"}, err_cnt,  ec);
        chk({tag, "_smp"}, smp_cnt,  sc);
        chk({tag, "_ovf"}, overflow, ov);
    endtask

    initial begin
        int cnt;
        int n;
        rst = 1; start = 0; num_samples = '0; in_valid = 0;
        in_a = '0; in_b = '0; in_r = '0;
        repeat (3) @(negedge clk);
        chk_results("reset", 0, 0, 0, 0, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_ready", in_ready, 0);
        rst = 0;
        cmp_en = 1;

        // Exact products only
        set_tuple(0, 3, 5, 15); set_tuple(1, 255, 255, 65025);
        set_tuple(2, 0, 7, 0);  set_tuple(3, 16, 16, 256);
        do_run(4, 100, 0);
        chk_results("exact", 0, 0, 0, 4, 0);

        // Errors in both directions
        set_tuple(0, 15, 15, 209); set_tuple(1, 3, 5, 31);
        do_run(2, 100, 0);
        chk_results("mixed", 32, 16, 2, 2, 0);

        // Valid held high beyond target
        gen_random(3);
        do_run(3, 100, 0);
        chk("bound_smp", smp_cnt, 3);

        // Saturation of a 17-bit sum
        for (int i = 0; i < 3; i++) set_tuple(i, 0, 0, 65535);
        do_run(3, 100, 0);
        chk_results("sat", 131071, 65535, 3, 3, 1);

        // Zero-length run
        do_run(0, 100, 0);
        chk_results("zero", 0, 0, 0, 0, 0);

        // start during RUN is ignored
        set_tuple(0, 10, 10, 100); set_tuple(1, 2, 2, 9);
        do_run(2, 100, 1);
        chk_results("ign_start", 5, 5, 1, 2, 0);

        // Reset mid-run after one accept
        @(negedge clk);
        start = 1; num_samples = CNT_W'(4);
        @(negedge clk);
        start = 0; in_valid = 1; in_a = 8'd2; in_b = 8'd3; in_r = 16'd0;
        @(negedge clk);
        in_valid = 0;
        repeat (3) @(negedge clk);
        chk("pre_rst_sum", sum_ed, 6);
        chk("pre_rst_smp", smp_cnt, 1);
        #2 rst = 1;
        #1;
        chk_results("rst_mid", 0, 0, 0, 0, 0);
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_ready", in_ready, 0);
        chk("rst_mid_done", done, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 0;
        cnt = 0;
        while (cnt < 5) begin
            @(negedge clk);
            cnt++;
        end

        // Fresh runs after reset, randomised
        for (int k = 0; k < 10; k++) begin
            n = $urandom_range(40, 1);
            gen_random(n);
            do_run(n, $urandom_range(100, 40), 0);
            chk("rand_smp", smp_cnt, n);
        end

        @(negedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
